uart_rx_fifo: RTL

- Parametrised UART receiver, successor to the board-level 115200 8N1 receiver.
- Runs entirely in the system clock domain. There is no derived bit clock; it uses an enable-based bit-timing counter.
- Supports configurable data width, parity and stop bits, and detects start-glitch, framing and parity errors.
- Buffers received words in a small FIFO with a valid/ready output, for consumption by display, debug and command logic on the Nexys A7 designs.

---
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-side valid/ready stream carrying one UART word per transfer.
// master = producer (receiver), slave = consumer.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with enable-based bit timing, parity/framing checks and a small receive FIFO.
// All logic runs in the system clock domain; rxd is synchronised before use.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_fifo_if.master rx_if,
  output logic           frame_err,
  output logic           parity_err,
  output logic           overrun,
  output logic           busy,
  output logic [7:0]     rx_count
);

  localparam int unsigned CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned TMR_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StBreak
  } state_t;

  state_t                r_state;
  logic                  r_sync1, r_rs, r_rs_prev;
  logic [TMR_W-1:0]      r_tmr;
  logic [BIT_W-1:0]      r_bit_idx;
  logic                  r_stop_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_ok;
  logic                  r_frame_err, r_parity_err, r_overrun;

  logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [PTR_W:0]        r_cnt;
  logic [7:0]            r_rx_count;

  logic w_tick, w_last_stop, w_stop_done, w_push;
  logic w_empty, w_full, w_pop, w_wr;

  assign w_tick      = (r_tmr == '0);
  assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;
  assign w_stop_done = (r_state == StStop) && w_tick && r_rs && w_last_stop;
  assign w_push      = w_stop_done && r_par_ok;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_FULL);
  assign w_pop   = rx_if.rx_ready && !w_empty;
  // A full FIFO still accepts the word when the head leaves on the same cycle.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_rs      <= 1'b1;
      r_rs_prev <= 1'b1;
    end else begin
      r_sync1   <= rxd;
      r_rs      <= r_sync1;
      r_rs_prev <= r_rs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_tmr        <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= 1'b0;
      r_shift      <= '0;
      r_par_ok     <= 1'b1;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      if (!w_tick) r_tmr <= r_tmr - 1'b1;
      case (r_state)
        StIdle: begin
          if (r_rs_prev && !r_rs) begin
            r_state <= StStart;
            r_tmr   <= TMR_HALF;
          end
        end
        StStart: begin
          if (w_tick) begin
            if (r_rs) begin
              r_state <= StIdle;
            end else begin
              r_state   <= StData;
              r_tmr     <= TMR_FULL;
              r_bit_idx <= '0;
              r_par_ok  <= 1'b1;
            end
          end
        end
        StData: begin
          if (w_tick) begin
            r_shift <= {r_rs, r_shift[DATA_BITS-1:1]};
            r_tmr   <= TMR_FULL;
            if (r_bit_idx == BIT_LAST) begin
              r_state    <= (PARITY != 0) ? StParity : StStop;
              r_stop_idx <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        StParity: begin
          if (w_tick) begin
            // XOR over data and parity bit is 1 for odd parity, 0 for even.
            r_par_ok <= ((^r_shift) ^ r_rs) == (PARITY == 1);
            r_state  <= StStop;
            r_tmr    <= TMR_FULL;
          end
        end
        StStop: begin
          if (w_tick) begin
            if (!r_rs) begin
              r_frame_err <= 1'b1;
              r_state     <= StBreak;
            end else if (w_last_stop) begin
              r_parity_err <= !r_par_ok;
              r_state      <= StIdle;
            end else begin
              r_stop_idx <= 1'b1;
              r_tmr      <= TMR_FULL;
            end
          end
        end
        StBreak: begin
          if (r_rs) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_rx_count <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_wptr     <= r_wptr + 1'b1;
        r_rx_count <= r_rx_count + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_wr) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign rx_if.rx_data  = w_empty ? '0 : r_mem[r_rptr];
  assign rx_if.rx_valid = !w_empty;
  assign frame_err      = r_frame_err;
  assign parity_err     = r_parity_err;
  assign overrun        = r_overrun;
  assign busy           = (r_state != StIdle);
  assign rx_count       = r_rx_count;

endmodule
